// File: rtl/imu_spi_sampler.sv
// SPI mode-0 master that periodically reads one 16-bit IMU register and
// presents the result on a valid/ready output with a sticky overrun flag.
module imu_spi_sampler #(
  parameter int CLK_DIV = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter logic [6:0] REG_ADDR = 7'h3B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic [15:0] measurement,
  output logic        meas_valid,
  input  logic        meas_ready,
  output logic        busy,
  output logic        overrun,
  input  logic        clr_overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   tx;
  logic [15:0]   rx;
  logic          tick;
  logic          div_done;
  logic          new_sample;

  assign tick       = enable && (period_cnt == PER_LAST);
  assign div_done   = (div_cnt == DIV_LAST);
  assign new_sample = (state == CS_HOLD) && div_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!enable || period_cnt == PER_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx          <= '0;
      rx          <= '0;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      spi_cs_n    <= 1'b1;
      busy        <= 1'b0;
      measurement <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ticks arriving while a transaction is in flight are simply dropped.
          if (tick) begin
            tx       <= {1'b1, REG_ADDR, 16'h0000};
            spi_mosi <= 1'b1;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (div_done) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!div_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              // Only the last 16 bits survive, so the address phase falls out.
              spi_sclk <= 1'b1;
              rx       <= {rx[14:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              tx       <= {tx[22:0], 1'b0};
              spi_mosi <= tx[22];
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                state   <= CS_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        CS_HOLD: begin
          if (div_done) begin
            div_cnt  <= '0;
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (new_sample) begin
        measurement <= rx;
        meas_valid  <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end

      // A set on the same edge as a clear takes priority.
      if (new_sample && meas_valid && !meas_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imu_spi_sampler.sv
// Directed bench for imu_spi_sampler with a mode-0 slave model on the SPI pins.
module tb_imu_spi_sampler;

  localparam int CLK_DIV = 2;
  localparam int SAMPLE_PERIOD = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic [15:0] measurement;
  logic        meas_valid;
  logic        meas_ready = 1'b0;
  logic        busy;
  logic        overrun;
  logic        clr_overrun = 1'b0;

  imu_spi_sampler #(
    .CLK_DIV(CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .REG_ADDR(7'h3B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .spi_miso(spi_miso),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n),
    .measurement(measurement),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .busy(busy),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor, sampled on the falling clk edge.
  logic [15:0] slave_q[$];
  logic [23:0] slave_sr = '0;
  logic [23:0] mosi_word = '0;
  int          bit_idx = 0;
  int          fall_count = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] next_word;
  logic [23:0] full_word;

  always @(negedge clk) begin
    prev_cs   <= spi_cs_n;
    prev_sclk <= spi_sclk;
    if (prev_cs && !spi_cs_n) begin
      if (slave_q.size() > 0) next_word = slave_q.pop_front();
      else next_word = 16'hDEAD;
      full_word = {8'hC7, next_word};
      slave_sr   <= full_word;
      spi_miso   <= full_word[23];
      fall_count <= fall_count + 1;
      bit_idx    <= 0;
      mosi_word  <= '0;
    end else if (!spi_cs_n && prev_sclk && !spi_sclk) begin
      slave_sr <= {slave_sr[22:0], 1'b0};
      spi_miso <= slave_sr[22];
    end
    if (!spi_cs_n && !prev_sclk && spi_sclk) begin
      mosi_word <= {mosi_word[22:0], spi_mosi};
      bit_idx   <= bit_idx + 1;
    end
  end

  typedef struct {
    logic [15:0] word;
    logic        ready;
    logic [15:0] exp_meas;
    logic        exp_valid;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (spi_cs_n !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (spi_cs_n !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL cs_fall_timeout actual=%0d cycles required=cs_n low", n);
    end
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (spi_cs_n !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (spi_cs_n !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cs_rise_timeout actual=%0d cycles required=cs_n high", n);
    end
  endtask

  task automatic wait_bits(input int b);
    int k;
    k = 0;
    while (bit_idx < b && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("bit_reached", 32'(bit_idx >= b), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    meas_ready = 1'b0;
    clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int n;
  int last_fall;
  int fc;

  initial begin
    vecs[0] = '{16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[1] = '{16'h0002, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[2] = '{16'h0003, 1'b1, 16'h0003, 1'b1, 1'b0};
    vecs[3] = '{16'h1111, 1'b0, 16'h1111, 1'b1, 1'b0};
    vecs[4] = '{16'h2222, 1'b0, 16'h2222, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_meas", 32'(measurement), 32'd0);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Single read
    @(negedge clk);
    slave_q.push_back(16'hA5C3);
    enable = 1'b1;
    meas_ready = 1'b1;
    wait_fall(n);
    last_fall = cyc;
    check("single_start_delay", 32'(n), 32'd120);
    check("single_busy", 32'(busy), 32'd1);
    wait_rise(n);
    check("single_cs_low_len", 32'(n), 32'd100);
    check("single_meas", 32'(measurement), 32'hA5C3);
    check("single_valid", 32'(meas_valid), 32'd1);
    check("single_busy_done", 32'(busy), 32'd0);
    check("single_mosi", 32'(mosi_word), 32'hBB0000);
    check("single_bits", 32'(bit_idx), 32'd24);
    @(negedge clk);
    check("single_valid_pulse", 32'(meas_valid), 32'd0);

    // Periodic stream followed by backpressure
    for (int i = 0; i < 5; i++) begin
      slave_q.push_back(vecs[i].word);
      meas_ready = vecs[i].ready;
      wait_fall(n);
      check($sformatf("vec%0d_spacing", i), 32'(cyc - last_fall), 32'd120);
      last_fall = cyc;
      wait_rise(n);
      check($sformatf("vec%0d_meas", i), 32'(measurement), 32'(vecs[i].exp_meas));
      check($sformatf("vec%0d_valid", i), 32'(meas_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      if (vecs[i].ready) begin
        @(negedge clk);
        check($sformatf("vec%0d_consumed", i), 32'(meas_valid), 32'd0);
      end
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_keeps_valid", 32'(meas_valid), 32'd1);
    check("clr_keeps_meas", 32'(measurement), 32'h2222);
    meas_ready = 1'b1;
    @(negedge clk);
    check("late_consume", 32'(meas_valid), 32'd0);
    enable = 1'b0;

    // Transfer and new sample on the same edge
    do_reset();
    enable = 1'b1;
    slave_q.push_back(16'h1234);
    wait_fall(n);
    wait_rise(n);
    check("simul_first_valid", 32'(meas_valid), 32'd1);
    slave_q.push_back(16'h5678);
    wait_fall(n);
    repeat (99) @(negedge clk);
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    check("simul_cs_rise", 32'(spi_cs_n), 32'd1);
    check("simul_meas", 32'(measurement), 32'h5678);
    check("simul_valid", 32'(meas_valid), 32'd1);
    check("simul_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    check("simul_valid_hold", 32'(meas_valid), 32'd1);
    enable = 1'b0;

    // Reset in the middle of the shift phase
    do_reset();
    enable = 1'b1;
    meas_ready = 1'b1;
    slave_q.push_back(16'h0F0F);
    wait_fall(n);
    wait_bits(10);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_valid", 32'(meas_valid), 32'd0);
    check("abort_meas", 32'(measurement), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    slave_q.push_back(16'h7E7E);
    wait_fall(n);
    check("abort_restart_delay", 32'(n), 32'd120);
    wait_rise(n);
    check("abort_next_meas", 32'(measurement), 32'h7E7E);
    enable = 1'b0;

    // Enable dropped mid-transaction
    do_reset();
    enable = 1'b1;
    meas_ready = 1'b1;
    slave_q.push_back(16'h0BEE);
    wait_fall(n);
    wait_bits(5);
    enable = 1'b0;
    wait_rise(n);
    check("endrop_meas", 32'(measurement), 32'h0BEE);
    check("endrop_valid", 32'(meas_valid), 32'd1);
    fc = fall_count;
    repeat (300) @(negedge clk);
    check("endrop_no_more_cs", 32'(fall_count), 32'(fc));
    check("endrop_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
